// File: rtl/arp_rx.sv
// ARP receive parser: checks each incoming ARP payload and records the sender
// MAC/IP of accepted packets. It flags a reply when the packet is a request
// for the local IP address.
module arp_rx #(
    parameter logic [31:0] P_SRC_IP_ADDR = {8'd192, 8'd168, 8'd100, 8'd99}
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dymanic_src_ip,
    input  logic        i_src_ip_valid,
    input  logic [63:0] s_axis_arp_data,
    input  logic [79:0] s_axis_arp_user,
    input  logic [7:0]  s_axis_arp_keep,
    input  logic        s_axis_arp_last,
    input  logic        s_axis_arp_valid,
    output logic [47:0] o_recv_target_mac,
    output logic [31:0] o_recv_target_ip,
    output logic        o_recv_target_valid,
    output logic        o_arp_reply
);

    // Beat index within the current frame. It saturates so that long padding cannot wrap it.
    logic [2:0]  beat_cnt_p0;
    // Sticky: some check already failed earlier in this frame.
    logic        frame_bad_p0;
    logic [31:0] local_ip;
    // Parsed fields. These are data only and are qualified by the control path.
    logic        op_req_p0;
    logic [47:0] sender_mac_p0;
    logic [31:0] sender_ip_p0;
    logic        beat_ok;
    logic        frame_ok;

    // Keep bytes, frame length and source MAC do not affect parsing.
    logic        unused_bits;
    assign unused_bits = ^{s_axis_arp_keep, s_axis_arp_user[79:16]};

    // Check the current beat, and decide whether a last beat completes a good frame.
    always_comb begin
        beat_ok = 1'b1;
        case (beat_cnt_p0)
            3'd0: beat_ok = (s_axis_arp_data[63:48] == 16'd1)
                         && (s_axis_arp_data[47:32] == 16'h0800)
                         && (s_axis_arp_data[31:24] == 8'd6)
                         && (s_axis_arp_data[23:16] == 8'd4)
                         && ((s_axis_arp_data[15:0] == 16'd1) || (s_axis_arp_data[15:0] == 16'd2))
                         && (s_axis_arp_user[15:0] == 16'h0806);
            3'd3: beat_ok = (s_axis_arp_data[63:32] == local_ip);
            default: beat_ok = 1'b1;
        endcase
        // A frame must reach beat 3 (the target IP) before its last beat.
        frame_ok = !frame_bad_p0 && beat_ok && (beat_cnt_p0 >= 3'd3);
    end

    // Capture the sender fields and the opcode as their beats arrive.
    always_ff @(posedge i_clk) begin
        if (s_axis_arp_valid) begin
            case (beat_cnt_p0)
                3'd0: op_req_p0 <= (s_axis_arp_data[15:0] == 16'd1);
                3'd1: begin
                    sender_mac_p0        <= s_axis_arp_data[63:16];
                    sender_ip_p0[31:16]  <= s_axis_arp_data[15:0];
                end
                3'd2: sender_ip_p0[15:0] <= s_axis_arp_data[63:48];
                default: ;
            endcase
        end
    end

    // Track frame progress and the local IP. Publish results the cycle after a good last beat.
    // After a reset in mid-frame, the leftover beats are parsed from beat 0 and fail the header checks.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat_cnt_p0         <= 3'd0;
            frame_bad_p0        <= 1'b0;
            local_ip            <= P_SRC_IP_ADDR;
            o_recv_target_mac   <= 48'd0;
            o_recv_target_ip    <= 32'd0;
            o_recv_target_valid <= 1'b0;
            o_arp_reply         <= 1'b0;
        end else begin
            o_recv_target_valid <= 1'b0;
            o_arp_reply         <= 1'b0;
            if (i_src_ip_valid) begin
                local_ip <= i_dymanic_src_ip;
            end
            if (s_axis_arp_valid) begin
                if (s_axis_arp_last) begin
                    beat_cnt_p0  <= 3'd0;
                    frame_bad_p0 <= 1'b0;
                    if (frame_ok) begin
                        o_recv_target_mac   <= sender_mac_p0;
                        o_recv_target_ip    <= sender_ip_p0;
                        o_recv_target_valid <= 1'b1;
                        o_arp_reply         <= op_req_p0;
                    end
                end else begin
                    beat_cnt_p0  <= (beat_cnt_p0 == 3'd7) ? 3'd7 : beat_cnt_p0 + 3'd1;
                    frame_bad_p0 <= frame_bad_p0 | !beat_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// Directed testbench for arp_rx. Each step builds a frame, sends it, and
// checks the outputs against hand-computed values.
module tb_arp_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dyn_ip = 32'd0;
    logic        dyn_ip_vld = 1'b0;
    logic [63:0] data = 64'd0;
    logic [79:0] user = 80'd0;
    logic [7:0]  keep = 8'hFF;
    logic        last = 1'b0;
    logic        valid = 1'b0;
    logic [47:0] t_mac;
    logic [31:0] t_ip;
    logic        t_vld;
    logic        reply;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] fb [8];
    int          fnb;

    localparam logic [47:0] MAC1 = 48'h00_0a_35_01_02_03;
    localparam logic [31:0] IP1  = 32'hc0a8640a;
    localparam logic [47:0] MAC2 = 48'h11_22_33_44_55_66;
    localparam logic [31:0] IP2  = 32'h0a000005;
    localparam logic [47:0] MAC3 = 48'h02_00_00_00_00_01;
    localparam logic [31:0] IP3  = 32'h0a000002;
    localparam logic [31:0] LOC  = 32'hc0a86463;
    localparam logic [31:0] NEWL = 32'h0a000001;

    arp_rx dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_dymanic_src_ip    (dyn_ip),
        .i_src_ip_valid      (dyn_ip_vld),
        .s_axis_arp_data     (data),
        .s_axis_arp_user     (user),
        .s_axis_arp_keep     (keep),
        .s_axis_arp_last     (last),
        .s_axis_arp_valid    (valid),
        .o_recv_target_mac   (t_mac),
        .o_recv_target_ip    (t_ip),
        .o_recv_target_valid (t_vld),
        .o_arp_reply         (reply)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [15:0] op, input logic [47:0] smac, input logic [31:0] sip,
                         input logic [31:0] tip, input logic [15:0] ptype,
                         input logic [15:0] etype, input int nb);
        fb[0] = {16'd1, ptype, 8'd6, 8'd4, op};
        fb[1] = {smac, sip[31:16]};
        fb[2] = {sip[15:0], 48'd0};
        fb[3] = {tip, 32'd0};
        for (int i = 4; i < 8; i++) fb[i] = 64'd0;
        fnb  = nb;
        user = {16'd28, smac, etype};
    endtask

    task automatic send_range(input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) begin
            if (gap) begin
                valid = 1'b0;
                @(posedge clk); #1;
            end
            data  = fb[i];
            last  = (i == fnb - 1);
            valid = 1'b1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    // Checks the cycle right after a last beat, then checks that the pulses drop one cycle later.
    task automatic expect_result(input string tag, input logic v, input logic r,
                                 input logic [47:0] mac, input logic [31:0] ip, input bit settle);
        chk({tag, "_valid"}, t_vld, v);
        chk({tag, "_reply"}, reply, r);
        chk({tag, "_mac"}, t_mac, mac);
        chk({tag, "_ip"}, t_ip, ip);
        if (settle) begin
            @(posedge clk); #1;
            chk({tag, "_valid_drop"}, t_vld, 1'b0);
            chk({tag, "_reply_drop"}, reply, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_result("reset", 1'b0, 1'b0, 48'd0, 32'd0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Request for the default local IP
        build(16'd1, MAC1, IP1, LOC, 16'h0800, 16'h0806, 6);
        send_range(0, 5, 1'b0);
        expect_result("req", 1'b1, 1'b1, MAC1, IP1, 1'b1);

        // Reply with the same addresses
        build(16'd2, MAC1, IP1, LOC, 16'h0800, 16'h0806, 6);
        send_range(0, 5, 1'b0);
        expect_result("rsp", 1'b1, 1'b0, MAC1, IP1, 1'b1);

        // Request for a foreign IP
        build(16'd1, MAC2, IP2, 32'hc0a86432, 16'h0800, 16'h0806, 6);
        send_range(0, 5, 1'b0);
        expect_result("foreign", 1'b0, 1'b0, MAC1, IP1, 1'b1);

        // Load a new local IP
        dyn_ip = NEWL;
        dyn_ip_vld = 1'b1;
        @(posedge clk); #1;
        dyn_ip_vld = 1'b0;
        build(16'd1, MAC2, IP2, NEWL, 16'h0800, 16'h0806, 6);
        send_range(0, 5, 1'b0);
        expect_result("newip", 1'b1, 1'b1, MAC2, IP2, 1'b1);
        build(16'd1, MAC1, IP1, LOC, 16'h0800, 16'h0806, 6);
        send_range(0, 5, 1'b0);
        expect_result("oldip", 1'b0, 1'b0, MAC2, IP2, 1'b1);

        // Bad frames sent back-to-back, followed immediately by a good frame
        build(16'd1, MAC1, IP1, NEWL, 16'h86DD, 16'h0806, 6);
        send_range(0, 5, 1'b0);
        expect_result("bad_ptype", 1'b0, 1'b0, MAC2, IP2, 1'b0);
        build(16'd1, MAC1, IP1, NEWL, 16'h0800, 16'h0800, 6);
        send_range(0, 5, 1'b0);
        expect_result("bad_etype", 1'b0, 1'b0, MAC2, IP2, 1'b0);
        build(16'd1, MAC1, IP1, NEWL, 16'h0800, 16'h0806, 3);
        send_range(0, 2, 1'b0);
        expect_result("bad_short", 1'b0, 1'b0, MAC2, IP2, 1'b0);
        build(16'd1, MAC3, IP3, NEWL, 16'h0800, 16'h0806, 4);
        send_range(0, 3, 1'b0);
        expect_result("b2b_good", 1'b1, 1'b1, MAC3, IP3, 1'b1);

        // Good frame with an idle cycle before every beat
        build(16'd2, MAC1, IP1, NEWL, 16'h0800, 16'h0806, 6);
        send_range(0, 5, 1'b1);
        expect_result("gaps", 1'b1, 1'b0, MAC1, IP1, 1'b1);
        @(posedge clk); #1;
        chk("gaps_quiet", t_vld, 1'b0);

        // Reset asserted at beat 2 of a frame; the rest of that frame must be dropped
        build(16'd1, MAC2, IP2, NEWL, 16'h0800, 16'h0806, 6);
        send_range(0, 1, 1'b0);
        rst = 1'b1;
        #2;
        chk("midrst_mac", t_mac, 48'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_range(2, 5, 1'b0);
        expect_result("midrst", 1'b0, 1'b0, 48'd0, 32'd0, 1'b1);

        // After reset the local IP is the default again
        build(16'd1, MAC3, IP3, LOC, 16'h0800, 16'h0806, 6);
        send_range(0, 5, 1'b0);
        expect_result("post_rst", 1'b1, 1'b1, MAC3, IP3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
